// File: rtl/dbg_run_ctrl.sv
// Debug run-control sequencer: turns halt/resume/step/reset commands from the
// debug module into correctly sequenced halt/reset requests to the core.
module dbg_run_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int RST_CYCLES   = 2,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dbg_req_valid,
    input  logic [1:0] dbg_req_cmd,
    output logic       dbg_req_ready,
    output logic       dbg_rsp_valid,
    output logic       dbg_rsp_err,
    output logic       halt_req_o,
    output logic       reset_req_o,
    output logic       halted_o
);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_HALTING = 3'd1,
        S_HALTED  = 3'd2,
        S_STEP    = 3'd3,
        S_RESET   = 3'd4
    } state_t;

    localparam logic [1:0] CMD_HALT   = 2'b00;
    localparam logic [1:0] CMD_RESUME = 2'b01;
    localparam logic [1:0] CMD_STEP   = 2'b10;

    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] RST_LOAD   = 8'(RST_CYCLES - 1);

    state_t     state_reg;
    logic [7:0] cnt_reg;
    logic       accept;

    assign dbg_req_ready = (state_reg == S_RUN) || (state_reg == S_HALTED);
    assign accept        = dbg_req_valid && dbg_req_ready;

    // Core-facing outputs {halt_req, reset_req, halted} for the state being entered,
    // so they are registered alongside the state and never lag it.
    function automatic logic [2:0] outs_for(input state_t s);
        case (s)
            S_RUN:     outs_for = 3'b000;
            S_HALTING: outs_for = 3'b100;
            S_HALTED:  outs_for = 3'b101;
            S_STEP:    outs_for = 3'b000;
            S_RESET:   outs_for = 3'b110;
            default:   outs_for = 3'b100;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= RESET_HALTED ? S_HALTED : S_RUN;
            cnt_reg       <= 8'd0;
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_err   <= 1'b0;
            halt_req_o    <= RESET_HALTED;
            reset_req_o   <= 1'b0;
            halted_o      <= RESET_HALTED;
        end else begin
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_err   <= 1'b0;
            case (state_reg)
                S_RUN: begin
                    if (accept) begin
                        case (dbg_req_cmd)
                            CMD_HALT: begin
                                state_reg <= S_HALTING;
                                cnt_reg   <= DRAIN_LOAD;
                                {halt_req_o, reset_req_o, halted_o} <= outs_for(S_HALTING);
                            end
                            CMD_RESUME: dbg_rsp_valid <= 1'b1;
                            CMD_STEP: begin
                                // Stepping a running core is meaningless: reject it.
                                dbg_rsp_valid <= 1'b1;
                                dbg_rsp_err   <= 1'b1;
                            end
                            default: begin
                                state_reg <= S_RESET;
                                cnt_reg   <= RST_LOAD;
                                {halt_req_o, reset_req_o, halted_o} <= outs_for(S_RESET);
                            end
                        endcase
                    end
                end
                S_HALTED: begin
                    if (accept) begin
                        case (dbg_req_cmd)
                            CMD_HALT: dbg_rsp_valid <= 1'b1;
                            CMD_RESUME: begin
                                state_reg     <= S_RUN;
                                dbg_rsp_valid <= 1'b1;
                                {halt_req_o, reset_req_o, halted_o} <= outs_for(S_RUN);
                            end
                            CMD_STEP: begin
                                state_reg <= S_STEP;
                                {halt_req_o, reset_req_o, halted_o} <= outs_for(S_STEP);
                            end
                            default: begin
                                state_reg <= S_RESET;
                                cnt_reg   <= RST_LOAD;
                                {halt_req_o, reset_req_o, halted_o} <= outs_for(S_RESET);
                            end
                        endcase
                    end
                end
                S_STEP: begin
                    // One cycle with halt released lets exactly one fetch through.
                    state_reg <= S_HALTING;
                    cnt_reg   <= DRAIN_LOAD;
                    {halt_req_o, reset_req_o, halted_o} <= outs_for(S_HALTING);
                end
                S_HALTING: begin
                    if (cnt_reg == 8'd0) begin
                        state_reg     <= S_HALTED;
                        dbg_rsp_valid <= 1'b1;
                        {halt_req_o, reset_req_o, halted_o} <= outs_for(S_HALTED);
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                S_RESET: begin
                    if (cnt_reg == 8'd0) begin
                        state_reg <= S_HALTING;
                        cnt_reg   <= DRAIN_LOAD;
                        {halt_req_o, reset_req_o, halted_o} <= outs_for(S_HALTING);
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                default: begin
                    // Corrupted encoding: park the core halted, the safest known state.
                    state_reg <= S_HALTING;
                    cnt_reg   <= DRAIN_LOAD;
                    {halt_req_o, reset_req_o, halted_o} <= outs_for(S_HALTING);
                end
            endcase
        end
    end

endmodule
